// File: rtl/counter_run_control.sv
// Run/pause/step/clear sequencer: debounced keys drive a STOPPED/RUNNING FSM, a tick prescaler and a 4-bit digit.
// Latency: key held from edge E reaches the outputs after E+4+DEBOUNCE_CYCLES; no backpressure, outputs are free-running registers.

module counter_run_control_key #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic key_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic          level_dly_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          press_q;
    logic          press_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
        end
    end

    // The counter only survives while the synchronized level keeps disagreeing.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_comb begin
        press_d = level_dly_q & ~level_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level_q     <= 1'b1;
            level_dly_q <= 1'b1;
            cnt_q       <= '0;
            press_q     <= 1'b0;
        end else begin
            level_q     <= level_d;
            level_dly_q <= level_q;
            cnt_q       <= cnt_d;
            press_q     <= press_d;
        end
    end

    assign press = press_q;

endmodule

module counter_run_control #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TICK_CYCLES     = 50000000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       key_run_n,
    input  logic       key_step_n,
    input  logic       key_clear_n,
    output logic       count_enable,
    output logic       count_clear,
    output logic       running,
    output logic [3:0] number
);

    localparam int PW = $clog2(TICK_CYCLES);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } state_e;

    state_e        state_q;
    state_e        state_d;
    logic          run_evt;
    logic          step_evt;
    logic          clear_evt;
    logic          run_active;
    logic          tick;
    logic          advance;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic [3:0]    number_q;
    logic [3:0]    number_d;
    logic          cnt_en_q;
    logic          cnt_en_d;
    logic          cnt_clr_q;
    logic          cnt_clr_d;

    counter_run_control_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_run (
        .clock   (clock),
        .reset_n (reset_n),
        .key_n   (key_run_n),
        .press   (run_evt)
    );

    counter_run_control_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_step (
        .clock   (clock),
        .reset_n (reset_n),
        .key_n   (key_step_n),
        .press   (step_evt)
    );

    counter_run_control_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_clear (
        .clock   (clock),
        .reset_n (reset_n),
        .key_n   (key_clear_n),
        .press   (clear_evt)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= STOPPED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (run_evt) begin
            state_d = (state_q == STOPPED) ? RUNNING : STOPPED;
        end
    end

    // Tick and step decisions use the state before the edge, so run+step/tick both land.
    always_comb begin
        run_active = (state_q == RUNNING);
        tick       = run_active && (presc_q == PRESC_LAST);
        advance    = tick || (step_evt && !run_active);
    end

    always_comb begin
        number_d  = number_q;
        cnt_en_d  = 1'b0;
        cnt_clr_d = 1'b0;
        if (clear_evt) begin
            number_d  = 4'd0;
            cnt_clr_d = 1'b1;
        end else if (advance) begin
            number_d = number_q + 4'd1;
            cnt_en_d = 1'b1;
        end
    end

    always_comb begin
        presc_d = presc_q + PW'(1);
        if (clear_evt || tick || !run_active || (state_d != RUNNING)) begin
            presc_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc_q   <= '0;
            number_q  <= 4'd0;
            cnt_en_q  <= 1'b0;
            cnt_clr_q <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            number_q  <= number_d;
            cnt_en_q  <= cnt_en_d;
            cnt_clr_q <= cnt_clr_d;
        end
    end

    assign count_enable = cnt_en_q;
    assign count_clear  = cnt_clr_q;
    assign running      = (state_q == RUNNING);
    assign number       = number_q;

endmodule

// File: tb/tb_counter_run_control.sv
// Directed bench for counter_run_control with DEBOUNCE_CYCLES=4, TICK_CYCLES=8.

module tb_counter_run_control;

    localparam int DEB = 4;
    localparam int TCK = 8;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       key_run_n = 1'b1;
    logic       key_step_n = 1'b1;
    logic       key_clear_n = 1'b1;
    logic       count_enable;
    logic       count_clear;
    logic       running;
    logic [3:0] number;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int run_rise = 0;

    always #5 clock = ~clock;

    counter_run_control #(.DEBOUNCE_CYCLES(DEB), .TICK_CYCLES(TCK)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .key_run_n    (key_run_n),
        .key_step_n   (key_step_n),
        .key_clear_n  (key_clear_n),
        .count_enable (count_enable),
        .count_clear  (count_clear),
        .running      (running),
        .number       (number)
    );

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        int ce_n;
        int cc_n;
        int bad;
        ce_n = 0; cc_n = 0; bad = 0;
        reset_n = 1'b0;
        repeat (3) step();
        tests++; if (running !== 1'b0) begin fails++; $display("FAIL reset_running: got %b want 0", running); end
        tests++; if (number !== 4'd0) begin fails++; $display("FAIL reset_number: got %0d want 0", number); end
        tests++; if (count_enable !== 1'b0) begin fails++; $display("FAIL reset_ce: got %b want 0", count_enable); end
        tests++; if (count_clear !== 1'b0) begin fails++; $display("FAIL reset_cc: got %b want 0", count_clear); end
        reset_n = 1'b1;
        repeat (100) begin
            step();
            if (count_enable) ce_n++;
            if (count_clear) cc_n++;
            if (running !== 1'b0 || number !== 4'd0) bad++;
        end
        tests++; if (ce_n != 0) begin fails++; $display("FAIL idle_ce_pulses: got %0d want 0", ce_n); end
        tests++; if (cc_n != 0) begin fails++; $display("FAIL idle_cc_pulses: got %0d want 0", cc_n); end
        tests++; if (bad != 0) begin fails++; $display("FAIL idle_state: got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_step();
        int ce_n;
        ce_n = 0;
        for (int p = 0; p < 3; p++) begin
            key_step_n = 1'b0;
            for (int j = 0; j < 10; j++) begin
                step();
                if (count_enable) ce_n++;
                if (p == 0 && j == 7) begin
                    tests++; if (number !== 4'd0) begin fails++; $display("FAIL step_early: got %0d want 0", number); end
                end
                if (p == 0 && j == 8) begin
                    tests++; if (count_enable !== 1'b1 || number !== 4'd1) begin
                        fails++; $display("FAIL step_latency: got ce=%b num=%0d want ce=1 num=1", count_enable, number);
                    end
                end
            end
            key_step_n = 1'b1;
            repeat (10) begin
                step();
                if (count_enable) ce_n++;
            end
        end
        tests++; if (ce_n != 3) begin fails++; $display("FAIL step_pulses: got %0d want 3", ce_n); end
        tests++; if (number !== 4'd3) begin fails++; $display("FAIL step_number: got %0d want 3", number); end
        tests++; if (running !== 1'b0) begin fails++; $display("FAIL step_running: got %b want 0", running); end
        ce_n = 0;
        repeat (5) begin
            key_step_n = 1'b0;
            repeat (2) begin step(); if (count_enable) ce_n++; end
            key_step_n = 1'b1;
            repeat (2) begin step(); if (count_enable) ce_n++; end
        end
        repeat (12) begin step(); if (count_enable) ce_n++; end
        tests++; if (ce_n != 0) begin fails++; $display("FAIL bounce_pulses: got %0d want 0", ce_n); end
        tests++; if (number !== 4'd3) begin fails++; $display("FAIL bounce_number: got %0d want 3", number); end
    endtask

    task automatic test_run();
        int rel;
        logic exp_ce;
        logic [3:0] exp_num;
        key_run_n = 1'b0;
        repeat (8) step();
        tests++; if (running !== 1'b0) begin fails++; $display("FAIL run_early: got %b want 0", running); end
        step();
        tests++; if (running !== 1'b1) begin fails++; $display("FAIL run_latency: got %b want 1", running); end
        run_rise = cyc;
        step();
        key_run_n = 1'b1;
        rel = cyc - run_rise;
        while (rel < 128) begin
            step();
            rel = cyc - run_rise;
            exp_ce = (rel % 8 == 0);
            exp_num = 4'((3 + rel / 8) % 16);
            tests++; if (count_enable !== exp_ce || number !== exp_num || running !== 1'b1) begin
                fails++; $display("FAIL run_tick rel=%0d: got ce=%b num=%0d run=%b want ce=%b num=%0d run=1",
                                  rel, count_enable, number, running, exp_ce, exp_num);
            end
            if (rel == 40) key_step_n = 1'b0;
            if (rel == 50) key_step_n = 1'b1;
        end
    endtask

    task automatic test_clear();
        int rel;
        logic exp_ce;
        logic exp_cc;
        logic [3:0] exp_num;
        rel = cyc - run_rise;
        while (rel < 160) begin
            step();
            rel = cyc - run_rise;
            exp_cc = (rel == 147);
            exp_ce = (rel < 147 && rel % 8 == 0) || (rel > 147 && (rel - 147) % 8 == 0);
            exp_num = (rel < 147) ? 4'((3 + rel / 8) % 16) : 4'((rel - 147) / 8);
            tests++; if (count_enable !== exp_ce || count_clear !== exp_cc || number !== exp_num) begin
                fails++; $display("FAIL clear rel=%0d: got ce=%b cc=%b num=%0d want ce=%b cc=%b num=%0d",
                                  rel, count_enable, count_clear, number, exp_ce, exp_cc, exp_num);
            end
            if (rel == 138) key_clear_n = 1'b0;
            if (rel == 148) key_clear_n = 1'b1;
        end
    endtask

    task automatic test_priority();
        int rel;
        logic exp_ce;
        logic exp_cc;
        logic exp_run;
        logic [3:0] exp_num;
        rel = cyc - run_rise;
        while (rel < 250) begin
            step();
            rel = cyc - run_rise;
            exp_cc = (rel == 171);
            exp_ce = (rel == 163 || rel == 179 || rel == 187 || rel == 214 ||
                      rel == 222 || rel == 230 || rel == 238);
            exp_run = (rel < 189) || (rel >= 214 && rel < 238);
            if (rel < 163) exp_num = 4'd1;
            else if (rel < 171) exp_num = 4'd2;
            else if (rel < 179) exp_num = 4'd0;
            else if (rel < 187) exp_num = 4'd1;
            else if (rel < 214) exp_num = 4'd2;
            else if (rel < 222) exp_num = 4'd3;
            else if (rel < 230) exp_num = 4'd4;
            else if (rel < 238) exp_num = 4'd5;
            else exp_num = 4'd6;
            tests++; if (count_enable !== exp_ce || count_clear !== exp_cc || number !== exp_num || running !== exp_run) begin
                fails++; $display("FAIL priority rel=%0d: got ce=%b cc=%b num=%0d run=%b want ce=%b cc=%b num=%0d run=%b",
                                  rel, count_enable, count_clear, number, running, exp_ce, exp_cc, exp_num, exp_run);
            end
            if (rel == 162) key_clear_n = 1'b0;
            if (rel == 172) key_clear_n = 1'b1;
            if (rel == 180) key_run_n = 1'b0;
            if (rel == 190) key_run_n = 1'b1;
            if (rel == 205) begin key_run_n = 1'b0; key_step_n = 1'b0; end
            if (rel == 215) begin key_run_n = 1'b1; key_step_n = 1'b1; end
            if (rel == 229) key_run_n = 1'b0;
            if (rel == 239) key_run_n = 1'b1;
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        bad = 0;
        repeat (5) step();
        key_run_n = 1'b0;
        repeat (9) step();
        step();
        key_run_n = 1'b1;
        repeat (20) step();
        tests++; if (running !== 1'b1) begin fails++; $display("FAIL mid_pre_running: got %b want 1", running); end
        key_run_n = 1'b0;
        repeat (3) step();
        reset_n = 1'b0;
        #1;
        tests++; if (running !== 1'b0) begin fails++; $display("FAIL mid_reset_running: got %b want 0", running); end
        tests++; if (number !== 4'd0) begin fails++; $display("FAIL mid_reset_number: got %0d want 0", number); end
        tests++; if (count_enable !== 1'b0) begin fails++; $display("FAIL mid_reset_ce: got %b want 0", count_enable); end
        tests++; if (count_clear !== 1'b0) begin fails++; $display("FAIL mid_reset_cc: got %b want 0", count_clear); end
        step();
        step();
        reset_n = 1'b1;
        repeat (3) step();
        key_run_n = 1'b1;
        repeat (30) begin
            step();
            if (running !== 1'b0 || number !== 4'd0 || count_enable !== 1'b0) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL mid_after_release: got %0d bad cycles want 0", bad); end
        key_run_n = 1'b0;
        repeat (8) step();
        tests++; if (running !== 1'b0) begin fails++; $display("FAIL mid_rerun_early: got %b want 0", running); end
        step();
        tests++; if (running !== 1'b1) begin fails++; $display("FAIL mid_rerun: got %b want 1", running); end
        run_rise = cyc;
        step();
        key_run_n = 1'b1;
        repeat (6) step();
        tests++; if (count_enable !== 1'b0 || number !== 4'd0) begin
            fails++; $display("FAIL mid_pre_tick: got ce=%b num=%0d want ce=0 num=0", count_enable, number);
        end
        step();
        tests++; if (count_enable !== 1'b1 || number !== 4'd1) begin
            fails++; $display("FAIL mid_first_tick: got ce=%b num=%0d want ce=1 num=1", count_enable, number);
        end
    endtask

    initial begin
        test_reset();
        test_step();
        test_run();
        test_clear();
        test_priority();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/counter_run_control.md
# counter_run_control

Run/pause/step/clear sequencer for the board's free-running counter and seven-segment display path. It turns three raw pushbuttons into debounced press events. A two-state machine gates a prescaler that issues one-cycle count-enable ticks. It keeps a 4-bit digit value that feeds the seven-segment driver in place of the raw upper counter bits.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 1000000: cycles a synchronized key level must stay stable before it is accepted (20 ms at 50 MHz); minimum 2.
- TICK_CYCLES, default 50000000: cycles between count ticks while running (1 s at 50 MHz); minimum 2.

Ports:
- clock  input  1  50 MHz clock; all logic on its rising edge.
- reset_n  input  1  asynchronous active-low reset.
- key_run_n  input  1  raw active-low pushbutton; each press toggles STOPPED/RUNNING.
- key_step_n  input  1  raw active-low pushbutton; each press advances the digit by one while STOPPED.
- key_clear_n  input  1  raw active-low pushbutton; each press zeroes the digit and the prescaler.
- count_enable  output  1  one-cycle pulse, high in the cycle `number` has just advanced.
- count_clear  output  1  one-cycle pulse, high in the cycle `number` has just been zeroed.
- running  output  1  1 in RUNNING, 0 in STOPPED.
- number  output  4  current digit value, for seven_segment_display_driver.

## Operation
- Per key: 2-flop synchronizer, then debouncer.
  - The debouncer holds an accepted level, reset value 1 (released).
  - Its stability counter clears whenever the synchronized level equals the accepted level, or changes.
  - When the synchronized level has differed from the accepted level for DEBOUNCE_CYCLES consecutive cycles, the accepted level takes it.
- Press event: registered one-cycle pulse when an accepted level goes 1→0. Releases generate nothing. Holding a key gives exactly one event.
- FSM states: STOPPED (reset state) and RUNNING.
  - run event: STOPPED→RUNNING, RUNNING→STOPPED.
- Prescaler, width $clog2(TICK_CYCLES):
  - Counts only in RUNNING.
  - Tick when it equals TICK_CYCLES-1; it then wraps to 0.
  - Forced to 0 on the STOPPED→RUNNING transition, on clear, and in STOPPED.
- Digit update, priority order:
  1. clear event: number←0, count_clear←1.
  2. Otherwise a tick in RUNNING, or a step event while STOPPED: number←number+1 mod 16 (F wraps to 0), count_enable←1.
  3. Otherwise hold.
- Simultaneous events resolve in that priority order.
  - clear and step together: only the clear takes effect.
  - clear and tick together: only the clear takes effect, and the prescaler restarts.
- run with step, or run with tick: both use the state before the edge.
  - STOPPED + step + run: number increments, state becomes RUNNING.
  - RUNNING + tick + run: number increments, state becomes STOPPED.
- A step event while RUNNING is discarded.
- Reset mid-operation: all state returns to reset values immediately. Pending debounce progress is lost.

## Timing
- Reset values: running=0, number=0, count_enable=0, count_clear=0, all accepted key levels=1, prescaler=0, all debounce counters=0.
- count_enable, count_clear, running and number are registered and change together on the same edge.
- Key latency: a key held low from edge E is accepted on edge E+2+DEBOUNCE_CYCLES. The press event is high after edge E+3+DEBOUNCE_CYCLES. Outputs reflect it after edge E+4+DEBOUNCE_CYCLES.
- Tick period: the first count_enable comes TICK_CYCLES cycles after running rises. Later ones follow every TICK_CYCLES cycles while RUNNING.
- A bounce shorter than DEBOUNCE_CYCLES produces no event.
- The prescaler restarts from 0 on each resume. Pause and resume does not preserve a partial period.

## Test plan
Directed tests use DEBOUNCE_CYCLES=4 and TICK_CYCLES=8.
1. Reset, keys idle for 100 cycles → running=0, number=0, no count_enable or count_clear pulses.
2. key_run_n low for 10 cycles → running=1 at edge E+8. count_enable pulses every 8 cycles, the first 8 cycles after running rises. number goes 1,2,… and wraps F→0 on the 16th tick.
3. Stopped: pulse key_step_n low 3 times for 10 cycles each, separated by 10 cycles high → number=3, exactly 3 count_enable pulses. key_step_n toggling with 2-cycle lows → no change.
4. key_clear_n press while number=5 and RUNNING → number=0, one count_clear pulse. The next tick comes 8 cycles after the clear.
5. Align a clear event with a tick cycle → number=0, count_clear=1, count_enable=0. Align run and step events while STOPPED → number+1, running=1.
6. Assert reset_n low mid-RUNNING and mid-debounce → all outputs read 0 immediately. After release the digit does not count until a fresh, full-length run press.
